// File: rtl/dma_mm2s_lite_sequencer.sv
// Programs one AXI DMA MM2S transfer over AXI4-Lite (CR, SA, SA_MSB, LENGTH),
// waits for the completion interrupt, checks DMASR and clears the interrupt.
module dma_mm2s_lite_sequencer #(
  parameter int unsigned LEN_W          = 26,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] CR_VAL         = 32'h0000_5001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dest_addr,
  input  logic [31:0] byte_length,
  input  logic        start,
  input  logic        mm2s_introut,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] status,
  output logic [9:0]  m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic [9:0]  m_axi_lite_araddr,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic [1:0]  m_axi_lite_rresp,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WR_CR, S_WR_SA, S_WR_MSB, S_WR_LEN,
    S_WAIT_IRQ, S_RD_SR, S_WR_CLR, S_FIN
  } state_t;

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // DMASR bits that flag a failed transfer: DMAIntErr, DMASlvErr, DMADecErr, Err_Irq
  localparam logic [31:0]    SR_ERR_MASK = 32'h0000_4070;

  state_t             state, state_next;
  logic [63:0]        addr_q;
  logic [31:0]        len_q;
  logic               aw_done, w_done, ar_done;
  logic [CNT_W-1:0]   cnt;
  logic               error_q;
  logic [31:0]        status_q;
  logic               wr_state, b_hs, r_hs, len_bad, rd_bad, irq_timeout;

  assign wr_state    = (state == S_WR_CR) || (state == S_WR_SA) || (state == S_WR_MSB) ||
                       (state == S_WR_LEN) || (state == S_WR_CLR);
  assign b_hs        = wr_state && aw_done && w_done && m_axi_lite_bvalid;
  assign r_hs        = (state == S_RD_SR) && ar_done && m_axi_lite_rvalid;
  assign len_bad     = (len_q == '0) || ((len_q >> LEN_W) != '0);
  assign rd_bad      = (m_axi_lite_rresp != 2'b00) || ((m_axi_lite_rdata & SR_ERR_MASK) != '0);
  assign irq_timeout = (state == S_WAIT_IRQ) && !mm2s_introut && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_CHECK;
      S_CHECK:    state_next = len_bad ? S_FIN : S_WR_CR;
      S_WR_CR:    if (b_hs) state_next = (m_axi_lite_bresp != 2'b00) ? S_FIN : S_WR_SA;
      S_WR_SA:    if (b_hs) state_next = (m_axi_lite_bresp != 2'b00) ? S_FIN : S_WR_MSB;
      S_WR_MSB:   if (b_hs) state_next = (m_axi_lite_bresp != 2'b00) ? S_FIN : S_WR_LEN;
      S_WR_LEN:   if (b_hs) state_next = (m_axi_lite_bresp != 2'b00) ? S_FIN : S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (mm2s_introut)     state_next = S_RD_SR;
        else if (irq_timeout) state_next = S_FIN;
      end
      S_RD_SR:    if (r_hs) state_next = S_WR_CLR;
      S_WR_CLR:   if (b_hs) state_next = S_FIN;
      S_FIN:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy               = (state != S_IDLE) && (state != S_FIN);
    done               = (state == S_FIN);
    m_axi_lite_awvalid = wr_state && !aw_done;
    m_axi_lite_wvalid  = wr_state && !w_done;
    m_axi_lite_bready  = wr_state && aw_done && w_done;
    m_axi_lite_arvalid = (state == S_RD_SR) && !ar_done;
    m_axi_lite_rready  = (state == S_RD_SR) && ar_done;
    m_axi_lite_awaddr  = '0;
    m_axi_lite_wdata   = '0;
    m_axi_lite_araddr  = m_axi_lite_arvalid ? 10'h004 : '0;
    if (m_axi_lite_awvalid) begin
      case (state)
        S_WR_SA:  m_axi_lite_awaddr = 10'h018;
        S_WR_MSB: m_axi_lite_awaddr = 10'h01C;
        S_WR_LEN: m_axi_lite_awaddr = 10'h028;
        S_WR_CLR: m_axi_lite_awaddr = 10'h004;
        default:  m_axi_lite_awaddr = 10'h000;
      endcase
    end
    if (m_axi_lite_wvalid) begin
      case (state)
        S_WR_SA:  m_axi_lite_wdata = addr_q[31:0];
        S_WR_MSB: m_axi_lite_wdata = addr_q[63:32];
        S_WR_LEN: m_axi_lite_wdata = 32'(len_q[LEN_W-1:0]);
        S_WR_CLR: m_axi_lite_wdata = 32'h0000_5000;
        default:  m_axi_lite_wdata = CR_VAL;
      endcase
    end
  end

  // Per-channel completion flags are cleared on every state change so each
  // register write starts with both valids raised together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ar_done  <= 1'b0;
      cnt      <= '0;
      error_q  <= 1'b0;
      status_q <= '0;
    end else begin
      if (state != state_next) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        if (m_axi_lite_awvalid && m_axi_lite_awready) aw_done <= 1'b1;
        if (m_axi_lite_wvalid && m_axi_lite_wready)   w_done  <= 1'b1;
        if (m_axi_lite_arvalid && m_axi_lite_arready) ar_done <= 1'b1;
      end
      cnt <= (state == S_WAIT_IRQ) ? cnt + CNT_W'(1) : '0;
      if (state == S_IDLE && start) begin
        addr_q   <= dest_addr;
        len_q    <= byte_length;
        error_q  <= 1'b0;
        status_q <= '0;
      end else begin
        if (state == S_CHECK && len_bad)                error_q <= 1'b1;
        if (b_hs && m_axi_lite_bresp != 2'b00)          error_q <= 1'b1;
        if (irq_timeout)                                error_q <= 1'b1;
        if (r_hs) begin
          status_q <= m_axi_lite_rdata;
          if (rd_bad) error_q <= 1'b1;
        end
      end
    end
  end

  assign error  = error_q;
  assign status = status_q;

endmodule

// File: doc/dma_mm2s_lite_sequencer.md
Name: dma_mm2s_lite_sequencer

Overview:
Sequences one MM2S (memory-to-stream) transfer on an AXI DMA engine over its AXI4-Lite control port. On start it latches a 64-bit source address and a byte length, then programs the engine's control, address and length registers. It waits for the completion interrupt, reads and checks the status register, and clears the interrupt. It sits between the system command logic and the DMA IP's S_AXI_LITE slave, and reports busy, done and error to the command side.

Parameters:
LEN_W, 26, width of the engine's length register; legal byte_length range is 1..2^LEN_W-1
TIMEOUT_CYCLES, 1000000, number of cycles in WAIT_IRQ before a timeout error is declared
CR_VAL, 32'h0000_5001, DMACR value: RS=1, IOC_IrqEn=1, Err_IrqEn=1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
dest_addr  in  64  transfer source address, sampled when a start is accepted
byte_length  in  32  transfer byte count, sampled when a start is accepted
start  in  1  one-cycle request; honoured only in IDLE
mm2s_introut  in  1  DMA MM2S interrupt, level
busy  out  1  high from the cycle after an accepted start until the done pulse
done  out  1  one-cycle completion pulse (success or error)
error  out  1  valid with done; held until the next accepted start
status  out  32  last DMASR value read; 0 if no read has occurred
m_axi_lite_awaddr/awvalid/awready  out/out/in  10/1/1  AXI-Lite write address channel
m_axi_lite_wdata/wvalid/wready  out/out/in  32/1/1  AXI-Lite write data channel (no wstrb; all bytes written)
m_axi_lite_bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite write response channel
m_axi_lite_araddr/arvalid/arready  out/out/in  10/1/1  AXI-Lite read address channel
m_axi_lite_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI-Lite read data channel

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, latched address/length/counters 0. Reset mid-transaction drops the valids immediately; the DMA IP is reset alongside.
- States: IDLE → (start) CHECK → WR_CR → WR_SA → WR_MSB → WR_LEN → WAIT_IRQ → RD_SR → WR_CLR → FIN → IDLE. Any error goes to FIN with error=1.
- IDLE + start: latch dest_addr/byte_length, clear error and status, set busy next cycle. A start in any other state is ignored.
- CHECK (1 cycle): if byte_length==0 or byte_length[31:LEN_W]!=0, go to FIN with error=1 and no AXI traffic.
- Register writes (awaddr, wdata):
  - WR_CR: 0x00, CR_VAL
  - WR_SA: 0x18, addr[31:0]
  - WR_MSB: 0x1C, addr[63:32]
  - WR_LEN: 0x28, {0, len[LEN_W-1:0]}
  - WR_CLR: 0x04, 32'h0000_5000 (W1C of IOC_Irq and Err_Irq)
- Write handshake:
  - awvalid and wvalid rise together on state entry.
  - Each valid is held until its ready is sampled high, then dropped independently.
  - Once both channels have completed, bready=1 until bvalid; then bready=0.
  - bresp!=2'b00 → error, FIN. Otherwise advance.
  - Address/data are stable while their valid is high. Same-cycle ready on both channels is legal.
- WAIT_IRQ: a cycle counter starts at 0 on entry.
  - mm2s_introut=1 → RD_SR.
  - Counter reaching TIMEOUT_CYCLES-1 without the interrupt → error, FIN (no clear write).
  - If the interrupt and the terminal count coincide, the interrupt wins.
- RD_SR:
  - arvalid=1 with araddr=0x04 until arready.
  - rready=1 from the cycle after the AR handshake until rvalid.
  - Capture rdata into status.
  - rresp!=0, or any of rdata[4], [5], [6] or [14] set → error flag set, but WR_CLR is still performed. Then WR_CLR.
- FIN: done=1 for one cycle, busy=0 in the same cycle, error valid. Next cycle IDLE; a start is accepted from that cycle.
- araddr/awaddr hold 0 when their valid is low. wdata holds 0 when wvalid is low.
- Latency with zero-wait slaves (ready and bvalid high): start → done = 1 + 5 writes × 2 cycles + interrupt wait + read 2 cycles + 1.

Test Plan:
- Normal: dest_addr=64'h0000_0001_8000_0040, byte_length=4096, all readies high, interrupt 20 cycles after the LEN write, rdata=32'h0000_1002.
  - Writes in order: 0x00=0x5001, 0x18=0x80000040, 0x1C=0x00000001, 0x28=0x1000, then 0x04=0x5000.
  - done with error=0, status=0x1002.
- byte_length=0 and, separately, byte_length=32'h0400_0000 → done 2 cycles after start, error=1, no awvalid ever asserted.
- Back-pressure: awready delayed 3 cycles, wready 1 cycle, bvalid 4 cycles on each write → each valid held until its own ready, no duplicate writes, same register sequence.
- bresp=2'b10 on the SA write → no MSB/LEN writes, done with error=1.
- DMASR read returns 32'h0000_1022 (DMASlvErr) → clear write still issued, done with error=1, status=0x1022.
- Timeout (TIMEOUT_CYCLES=50, no interrupt) → done exactly 50 cycles after WAIT_IRQ entry, error=1.
- Start pulsed mid-transfer → ignored.
- Reset asserted mid-WR_LEN → all outputs 0 immediately.
- Start after reset release → new normal sequence from WR_CR.
